bitserial_mul_scheduler: RTL and testbench

- Round-robin scheduler that time-shares one bit-serial signed multiplier PE among NREQ requesters.
- Accepts operand pairs over valid/ready, loads them into the PE, and sequences the per-bit count and the end-of-product metronome.
- Captures the 2*BITWIDTH product and returns it with the requester ID over valid/ready.
- Sits between the PE-array operand fetch logic and a single shared multiplier PE.

---
 rtl/bitserial_mul_scheduler_pkg.sv | 22 ++
 rtl/bitserial_mul_scheduler_rr_arbiter.sv | 37 +++
 rtl/bitserial_mul_scheduler.sv | 159 +++++++++++++++
 tb/tb_bitserial_mul_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitserial_mul_scheduler_pkg.sv
// Shared definitions for the bit-serial multiplier scheduler: FSM encoding,
// the DRAIN timeout and a constant-function clog2 for parameter defaults.
package bitserial_mul_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Cycles DRAIN waits for the PE result before giving up on the operation.
  localparam int DRAIN_TIMEOUT = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bitserial_mul_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ; returns one-hot grant and its encoded index.
module bitserial_mul_scheduler_rr_arbiter
  import bitserial_mul_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bitserial_mul_scheduler.sv
// Time-shares one bit-serial signed multiplier PE among NREQ requesters.
// Optional BSMUL_ZERO_SKIP_EN: zero operands answer 0 directly, bypassing the PE.
module bitserial_mul_scheduler
  import bitserial_mul_scheduler_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int IDW      = clog2(NREQ),
  parameter int CW       = clog2(BITWIDTH) + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BITWIDTH-1:0] req_a,
  input  logic [NREQ*BITWIDTH-1:0] req_b,
  output logic                     mul_rst_n,
  output logic                     mul_data_in_valid,
  output logic [BITWIDTH-1:0]      mul_a,
  output logic [BITWIDTH-1:0]      mul_b,
  output logic [CW-1:0]            mul_last_count,
  output logic                     mul_metronome,
  input  logic                     mul_data_out_valid,
  input  logic [2*BITWIDTH-1:0]    mul_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*BITWIDTH-1:0]    rsp_data
);

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      id_q;
  logic [CW-1:0]       count;
  logic [1:0]          drain_cnt;
  logic                err_q;
  logic [NREQ-1:0]     gnt_onehot;
  logic [IDW-1:0]      gnt_idx;
  logic                grant_fire;
  logic                drain_timeout;
  logic [BITWIDTH-1:0] lane_a [NREQ];
  logic [BITWIDTH-1:0] lane_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*BITWIDTH +: BITWIDTH];
    assign lane_b[i] = req_b[i*BITWIDTH +: BITWIDTH];
  end

  bitserial_mul_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx)
  );

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // A grant needs the response buffer free now or being drained this cycle.
  assign grant_fire    = (state == IDLE) && (|req_valid) && (!rsp_valid || rsp_ready);
  assign req_ready     = (grant_fire && !rst) ? gnt_onehot : '0;
  assign mul_rst_n     = ~rst;
  assign mul_last_count = count;
  assign drain_timeout = (state == DRAIN) && !mul_data_out_valid &&
                         (drain_cnt == 2'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      id_q              <= '0;
      count             <= '0;
      drain_cnt         <= '0;
      err_q             <= 1'b0;
      mul_data_in_valid <= 1'b0;
      mul_metronome     <= 1'b0;
      mul_a             <= '0;
      mul_b             <= '0;
      rsp_valid         <= 1'b0;
      rsp_id            <= '0;
      rsp_data          <= '0;
    end else begin
      mul_data_in_valid <= 1'b0;
      mul_metronome     <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_fire) begin
            id_q  <= gnt_idx;
            count <= '0;
`ifdef BSMUL_ZERO_SKIP_EN
            if (lane_a[gnt_idx] == '0 || lane_b[gnt_idx] == '0) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_id    <= gnt_idx;
              rr_ptr    <= wrap_inc(gnt_idx);
            end else begin
              mul_a             <= lane_a[gnt_idx];
              mul_b             <= lane_b[gnt_idx];
              mul_data_in_valid <= 1'b1;
              state             <= LOAD;
            end
`else
            mul_a             <= lane_a[gnt_idx];
            mul_b             <= lane_b[gnt_idx];
            mul_data_in_valid <= 1'b1;
            state             <= LOAD;
`endif
          end
        end

        LOAD: begin
          rr_ptr <= wrap_inc(id_q);
          count  <= '0;
          state  <= COMPUTE;
        end

        // Metronome is registered, so it is raised one edge ahead of the last bit.
        COMPUTE: begin
          if (count == CW'(BITWIDTH - 1)) begin
            count     <= '0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            count         <= count + CW'(1);
            mul_metronome <= (count == CW'(BITWIDTH - 2));
          end
        end

        DRAIN: begin
          if (mul_data_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mul_dout;
            rsp_id    <= id_q;
            drain_cnt <= '0;
            state     <= IDLE;
          end else if (drain_timeout) begin
            err_q     <= 1'b1;
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A PE that never answers is a system fault; flag the first occurrence.
  assert property (@(posedge clk) disable iff (rst) !(drain_timeout && !err_q));

endmodule

// File: tb/tb_bitserial_mul_scheduler.sv
// Self-checking bench for bitserial_mul_scheduler with a behavioural PE model.
// Honours BSMUL_ZERO_SKIP_EN when the build defines it.
module tb_bitserial_mul_scheduler;

`ifdef BSMUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        mul_rst_n;
  logic        mul_data_in_valid;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [4:0]  mul_last_count;
  logic        mul_metronome;
  logic        mul_data_out_valid;
  logic [15:0] mul_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         lane;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [8];

  bitserial_mul_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_a              (req_a),
    .req_b              (req_b),
    .mul_rst_n          (mul_rst_n),
    .mul_data_in_valid  (mul_data_in_valid),
    .mul_a              (mul_a),
    .mul_b              (mul_b),
    .mul_last_count     (mul_last_count),
    .mul_metronome      (mul_metronome),
    .mul_data_out_valid (mul_data_out_valid),
    .mul_dout           (mul_dout),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_id             (rsp_id),
    .rsp_data           (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return p;
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (v[i]) idx = (idx == -1) ? i : -2;
    return idx;
  endfunction

  // PE model: latches operands on the strobe, answers the cycle after the metronome.
  logic signed [7:0] pe_a;
  logic signed [7:0] pe_b;
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      pe_a               <= '0;
      pe_b               <= '0;
      mul_data_out_valid <= 1'b0;
      mul_dout           <= 16'hDEAD;
    end else begin
      if (mul_data_in_valid) begin
        pe_a <= mul_a;
        pe_b <= mul_b;
      end
      mul_data_out_valid <= mul_metronome;
      mul_dout           <= mul_metronome ? ref_mul(pe_a, pe_b) : 16'hDEAD;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int lane, input logic [7:0] a, input logic [7:0] b);
    req_a[lane*8 +: 8] = a;
    req_b[lane*8 +: 8] = b;
    req_valid[lane]    = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitRsp(input int budget, output int cycles, output int rdy_seen);
    cycles   = 0;
    rdy_seen = 0;
    while (!rsp_valid && cycles < budget) begin
      if (req_ready != 0) rdy_seen++;
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic runVector(input int lane, input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
    bit         skip;
    int         lat;
    int         strobes;
    int         met_k;
    logic [4:0] lc2;
    logic [7:0] sa;
    logic [7:0] sb;
    skip    = ZSKIP && (a == 8'd0 || b == 8'd0);
    lat     = 0;
    strobes = 0;
    met_k   = 0;
    lc2     = '1;
    sa      = '0;
    sb      = '0;
    @(negedge clk);
    applyStimulus(lane, a, b);
    #1;
    checkOutput("grant one-hot", 32'(req_ready), 32'(1 << lane));
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      if (mul_data_in_valid) begin
        strobes++;
        sa = mul_a;
        sb = mul_b;
      end
      if (mul_metronome) met_k = k;
      if (k == 2) lc2 = mul_last_count;
      if (rsp_valid) lat = k;
    end
    checkOutput("rsp latency", lat, skip ? 1 : 11);
    checkOutput("rsp_data", 32'(rsp_data), 32'(prod));
    checkOutput("rsp_id", 32'(rsp_id), lane);
    checkOutput("load strobes", strobes, skip ? 0 : 1);
    if (!skip) begin
      checkOutput("mul_a", 32'(sa), 32'(a));
      checkOutput("mul_b", 32'(sb), 32'(b));
      checkOutput("metronome cycle", met_k, 9);
      checkOutput("first bit count", 32'(lc2), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("rsp cleared after accept", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [7:0]  rr_a [4];
    logic [7:0]  rr_b [4];
    int          gr_idx [5];
    int          gr_cyc [5];
    int          rs_id [5];
    int          rs_cyc [5];
    logic [15:0] rs_data [5];
    int          ngr;
    int          nrsp;
    int          cyc;
    int          rdy;
    int          stable_bad;
    int          rdy_bad;
    int          rsp_seen;

    vecs[0] = '{0, 8'hFD, 8'h05, 16'hFFF1};
    vecs[1] = '{1, 8'h80, 8'h80, 16'h4000};
    vecs[2] = '{2, 8'h7F, 8'h80, 16'hC080};
    vecs[3] = '{3, 8'h00, 8'hF9, 16'h0000};
    vecs[4] = '{1, 8'd100, 8'd3, 16'h012C};
    vecs[5] = '{0, 8'hFF, 8'hFF, 16'h0001};
    vecs[6] = '{2, 8'h7F, 8'h7F, 16'h3F01};
    vecs[7] = '{3, 8'd25, 8'h00, 16'h0000};
    rr_a = '{8'd3, 8'hCE, 8'd7, 8'h80};
    rr_b = '{8'hFC, 8'd2, 8'd9, 8'd1};

    rst       = 1'b1;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 0);
    checkOutput("reset mul_rst_n", 32'(mul_rst_n), 0);
    checkOutput("reset pe outputs", 32'({mul_data_in_valid, mul_metronome, mul_last_count, mul_a, mul_b}), 0);
    checkOutput("reset rsp outputs", 32'({rsp_valid, rsp_id, rsp_data}), 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mul_rst_n released", 32'(mul_rst_n), 1);

    for (int v = 0; v < 8; v++)
      runVector(vecs[v].lane, vecs[v].a, vecs[v].b, vecs[v].prod);

    // Round robin with all four requesters continuously valid.
    doReset();
    for (int i = 0; i < 5; i++) begin
      gr_idx[i] = -1; gr_cyc[i] = -100; rs_id[i] = -1; rs_cyc[i] = -100; rs_data[i] = 16'hxxxx;
    end
    ngr  = 0;
    nrsp = 0;
    for (int l = 0; l < 4; l++) applyStimulus(l, rr_a[l], rr_b[l]);
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 80 && nrsp < 5; c++) begin
      if (req_ready != 0 && ngr < 5) begin
        gr_idx[ngr] = onehotIdx(req_ready);
        gr_cyc[ngr] = c;
        ngr++;
      end
      if (rsp_valid && nrsp < 5) begin
        rs_id[nrsp]   = int'(rsp_id);
        rs_data[nrsp] = rsp_data;
        rs_cyc[nrsp]  = c;
        nrsp++;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("rr grant count", ngr, 5);
    checkOutput("rr response count", nrsp, 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr grant order", gr_idx[i], i % 4);
      if (i > 0) checkOutput("rr grant spacing", gr_cyc[i] - gr_cyc[i-1], 11);
      checkOutput("rr rsp_id", rs_id[i], i % 4);
      checkOutput("rr rsp_data", 32'(rs_data[i]), 32'(ref_mul(rr_a[i % 4], rr_b[i % 4])));
      checkOutput("rr rsp latency", rs_cyc[i] - gr_cyc[i], 11);
    end

    // Back-pressure: response held while req1 waits for the accept cycle.
    doReset();
    applyStimulus(0, 8'hFD, 8'h05);
    #1;
    checkOutput("hold grant req0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    applyStimulus(1, 8'd6, 8'hFE);
    #1;
    waitRsp(20, cyc, rdy);
    checkOutput("hold rsp arrives", 32'(rsp_valid), 1);
    checkOutput("hold no ready in flight", rdy, 0);
    checkOutput("hold rsp_data", 32'(rsp_data), 32'hFFF1);
    stable_bad = 0;
    rdy_bad    = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFF1 || rsp_id !== 2'd0) stable_bad++;
      if (req_ready != 0) rdy_bad++;
    end
    checkOutput("hold rsp stable", stable_bad, 0);
    checkOutput("hold no ready while buffer full", rdy_bad, 0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("grant on accept cycle", 32'(req_ready), 32'h2);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("buffer cleared on accept", 32'(rsp_valid), 0);
    waitRsp(20, cyc, rdy);
    checkOutput("req1 rsp latency", cyc, 10);
    checkOutput("req1 rsp_data", 32'(rsp_data), 32'hFFF4);
    checkOutput("req1 rsp_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while the PE is mid-product.
    doReset();
    applyStimulus(2, 8'd5, 8'd5);
    #1;
    checkOutput("abort grant req2", 32'(req_ready), 32'h4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
    end
    checkOutput("count before abort", 32'(mul_last_count), 4);
    rst = 1'b1;
    #1;
    checkOutput("mul_rst_n follows rst", 32'(mul_rst_n), 0);
    @(negedge clk);
    #1;
    checkOutput("abort pe outputs", 32'({mul_data_in_valid, mul_metronome, mul_last_count, mul_a, mul_b}), 0);
    checkOutput("abort rsp/ready", 32'({rsp_valid, rsp_id, rsp_data, req_ready}), 0);
    rst = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) rsp_seen++;
    end
    checkOutput("no rsp after abort", rsp_seen, 0);
    runVector(3, 8'hF9, 8'd9, 16'hFFC1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
